// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// AHB-Lite subordinate backed by a word-organised internal SRAM. Decodes the
// address phase, inserts WAIT_STATES wait cycles before each OKAY data phase,
// commits byte/half/word writes to the selected byte lanes and returns the
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
//
// Ports:
//   hclk       bus clock, rising-edge
//   hresetn    synchronous active-low reset
//   hsel       slave select from the decoder
//   haddr      byte address
//   htrans     transfer type (IDLE, BUSY, NONSEQ, SEQ)
//   hwrite     1 = write, 0 = read
//   hsize      000 byte, 001 half, 010 word
//   hwdata     write data (data phase)
//   hready     bus-level ready, qualifies the address phase
//   hrdata     read data
//   hreadyout  slave ready for the current data phase
//   hresp      0 OKAY, 1 ERROR
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]            wait_cnt;
    logic [3:0]            next_wait_cnt;
    logic [IDX_W+1:0]      addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  illegal;
    logic [63:0]           req_index;
    logic [IDX_W-1:0]      word_idx;
    logic [3:0]            lane_en;
    logic                  read_data_phase;

    // Response signalling depends only on the current state.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    // Address phases are only taken while this slave is itself ready, so a
    // master holding its next phase through a wait or ERR1 cycle is ignored
    // until the completing cycle.
    assign accept = hreadyout & hsel & hready & ((htrans == 2'b10) || (htrans == 2'b11));

    // Index compared at full width so no high address bits alias into range.
    assign req_index = 64'(haddr[ADDR_WIDTH-1:2]);
    assign illegal   = (req_index >= 64'(MEM_DEPTH))
                     || (hsize > 3'b010)
                     || ((hsize == 3'b001) && haddr[0])
                     || ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        case (state)
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ST_DATA;
                end else begin
                    next_wait_cnt = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: next_state = ST_ERR2;
            default: next_state = ST_IDLE;
        endcase
        if (accept) begin
            if (illegal) begin
                next_state = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                next_state    = ST_WAIT;
                next_wait_cnt = 4'(WAIT_STATES - 1);
            end else begin
                next_state = ST_DATA;
            end
        end
    end

    assign word_idx        = addr_q[IDX_W+1:2];
    assign read_data_phase = (state == ST_DATA) && !write_q;

    // Little-endian lane selection for the latched transfer.
    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            3'b000:  lane_en[addr_q[1:0]] = 1'b1;
            3'b001:  lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'b000;
            rdata_q  <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
            if (accept) begin
                addr_q  <= haddr[IDX_W+1:0];
                write_q <= hwrite;
                size_q  <= hsize;
            end
            if (read_data_phase) begin
                rdata_q <= mem[word_idx];
            end
        end
    end

    // A write only reaches the array in its DATA cycle, so errored transfers
    // and writes cut short by reset never touch memory.
    always_ff @(posedge hclk) begin
        if (hresetn && (state == ST_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // The DATA cycle presents the array word directly; rdata_q keeps it
    // stable afterwards.
    assign hrdata = read_data_phase ? mem[word_idx] : rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
// Scoreboard bench for ahb_sram_slave. Three instances with 0, 3 and 5 wait
// states share one bus; 'target' routes hsel and hready to one of them.
module tb_ahb_sram_slave;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        bit          nodata;
        bit          err;
        bit          is_read;
        logic [31:0] rdata;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel_bus;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          target;

    logic [31:0] rdata_v [3];
    logic        ready_v [3];
    logic        resp_v  [3];
    logic        sel_v   [3];
    logic        bus_ready;
    logic        hresp_sel;
    logic [31:0] hrdata_sel;

    int n_checks = 0;
    int n_errors = 0;

    xfer_t       stim_q [$];
    exp_t        exp_q [$];
    logic [31:0] model_mem [int];
    logic [31:0] last_rdata [3];

    always #5 hclk = ~hclk;

    assign sel_v[0]   = hsel_bus && (target == 0);
    assign sel_v[1]   = hsel_bus && (target == 1);
    assign sel_v[2]   = hsel_bus && (target == 2);
    assign bus_ready  = ready_v[target];
    assign hresp_sel  = resp_v[target];
    assign hrdata_sel = rdata_v[target];

    ahb_sram_slave #(.WAIT_STATES(0)) u_dut_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(sel_v[0]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(bus_ready), .hrdata(rdata_v[0]), .hreadyout(ready_v[0]), .hresp(resp_v[0])
    );

    ahb_sram_slave #(.WAIT_STATES(3)) u_dut_ws3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(sel_v[1]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(bus_ready), .hrdata(rdata_v[1]), .hreadyout(ready_v[1]), .hresp(resp_v[1])
    );

    ahb_sram_slave #(.WAIT_STATES(5)) u_dut_ws5 (
        .hclk(hclk), .hresetn(hresetn), .hsel(sel_v[2]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(bus_ready), .hrdata(rdata_v[2]), .hreadyout(ready_v[2]), .hresp(resp_v[2])
    );

    function automatic int ws_of(input int t);
        return (t == 0) ? 0 : (t == 1) ? 3 : 5;
    endfunction

    // Reference model: legality, lane merge and expected read data.
    function automatic exp_t model_accept(input xfer_t x);
        exp_t        r;
        int          key;
        logic [31:0] w;
        r.nodata  = !(x.sel && x.trans[1]);
        r.err     = 1'b0;
        r.is_read = !x.write;
        r.rdata   = 32'h0;
        if (!r.nodata) begin
            r.err = (x.addr[31:2] >= 30'd1024) || (x.size > 3'd2)
                 || ((x.size == 3'd1) && x.addr[0])
                 || ((x.size == 3'd2) && (x.addr[1:0] != 2'b00));
            if (!r.err) begin
                key = target * 4096 + int'(x.addr[11:2]);
                w = model_mem.exists(key) ? model_mem[key] : 32'hxxxxxxxx;
                if (x.write) begin
                    for (int b = 0; b < 4; b++) begin
                        bit en;
                        en = (x.size == 3'd2)
                          || ((x.size == 3'd1) && ((b / 2) == int'(x.addr[1])))
                          || ((x.size == 3'd0) && (b == int'(x.addr[1:0])));
                        if (en) w[8*b +: 8] = x.wdata[8*b +: 8];
                    end
                    model_mem[key] = w;
                end else begin
                    r.rdata = w;
                end
            end
        end
        return r;
    endfunction

    task automatic add_xfer(input logic sel, input logic [1:0] trans, input logic write,
                            input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.write = write;
        x.size = size; x.addr = addr; x.wdata = wdata;
        stim_q.push_back(x);
    endtask

    task automatic add_wr(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        add_xfer(1'b1, 2'b10, 1'b1, size, addr, wdata);
    endtask

    task automatic add_rd(input logic [2:0] size, input logic [31:0] addr);
        add_xfer(1'b1, 2'b10, 1'b0, size, addr, 32'h0);
    endtask

    task automatic bus_idle();
        hsel_bus = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; haddr = 32'h0; hwdata = 32'h0;
    endtask

    // Pipelined master plus scoreboard. Called at posedge+1: drives the current
    // address phase and the pending data phase's hwdata, checks the data phase
    // outputs, and pushes expectations when an address phase is accepted.
    task automatic run_scoreboard(input string tag);
        xfer_t       ap;
        xfer_t       dp;
        exp_t        e;
        bit          ap_valid;
        bit          dp_valid;
        bit          ready_now;
        int          low;
        int          cycles;
        int          exp_low;
        logic [31:0] exp_rd;
        ap_valid = 1'b0; dp_valid = 1'b0; low = 0; cycles = 0;
        if (stim_q.size() > 0) begin
            ap = stim_q.pop_front();
            ap_valid = 1'b1;
        end
        while ((ap_valid || dp_valid) && (cycles < 400)) begin
            if (ap_valid) begin
                hsel_bus = ap.sel; htrans = ap.trans; hwrite = ap.write;
                hsize = ap.size; haddr = ap.addr;
            end else begin
                hsel_bus = 1'b0; htrans = 2'b00;
            end
            hwdata = dp_valid ? dp.wdata : 32'h0;
            ready_now = bus_ready;
            if (dp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("[TB] FAIL %s scoreboard_empty: data phase with no expectation", tag);
                    dp_valid = 1'b0;
                end else if (!ready_now) begin
                    low++;
                    n_checks++;
                    if (hresp_sel !== exp_q[0].err) begin
                        n_errors++;
                        $display("[TB] FAIL %s low_cycle_hresp addr=%h: got %b want %b", tag, dp.addr, hresp_sel, exp_q[0].err);
                    end
                end else begin
                    e = exp_q.pop_front();
                    exp_low = e.nodata ? 0 : (e.err ? 1 : ws_of(target));
                    exp_rd  = (e.is_read && !e.err && !e.nodata) ? e.rdata : last_rdata[target];
                    n_checks++;
                    if (hresp_sel !== e.err) begin
                        n_errors++;
                        $display("[TB] FAIL %s hresp addr=%h: got %b want %b", tag, dp.addr, hresp_sel, e.err);
                    end
                    n_checks++;
                    if (low !== exp_low) begin
                        n_errors++;
                        $display("[TB] FAIL %s low_cycles addr=%h: got %0d want %0d", tag, dp.addr, low, exp_low);
                    end
                    n_checks++;
                    if (hrdata_sel !== exp_rd) begin
                        n_errors++;
                        $display("[TB] FAIL %s hrdata addr=%h: got %h want %h", tag, dp.addr, hrdata_sel, exp_rd);
                    end
                    last_rdata[target] = exp_rd;
                    dp_valid = 1'b0;
                end
            end
            if (ready_now && ap_valid) begin
                exp_q.push_back(model_accept(ap));
                dp = ap; dp_valid = 1'b1; low = 0;
                ap_valid = 1'b0;
                if (stim_q.size() > 0) begin
                    ap = stim_q.pop_front();
                    ap_valid = 1'b1;
                end
            end
            @(posedge hclk); #1;
            cycles++;
        end
        bus_idle();
        if (cycles >= 400) begin
            n_checks++; n_errors++;
            $display("[TB] FAIL %s timeout: transfers still pending after %0d cycles", tag, cycles);
        end
    endtask

    task automatic test_reset();
        bus_idle();
        hresetn = 1'b0;
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        for (int t = 0; t < 3; t++) last_rdata[t] = 32'h0;
        for (int c = 0; c < 3; c++) begin
            for (int t = 0; t < 3; t++) begin
                n_checks++;
                if ((ready_v[t] !== 1'b1) || (resp_v[t] !== 1'b0) || (rdata_v[t] !== 32'h0)) begin
                    n_errors++;
                    $display("[TB] FAIL reset_idle inst=%0d cycle=%0d: got ready=%b resp=%b rdata=%h want 1 0 00000000",
                             t, c, ready_v[t], resp_v[t], rdata_v[t]);
                end
            end
            @(posedge hclk); #1;
        end
    endtask

    task automatic test_word_rw();
        target = 0;
        add_wr(3'd2, 32'h10, 32'hDEADBEEF);
        add_rd(3'd2, 32'h10);
        add_wr(3'd2, 32'hFFC, 32'hA5A5_0F0F);
        add_wr(3'd2, 32'h0, 32'hCAFE_F00D);
        add_rd(3'd2, 32'hFFC);
        add_rd(3'd2, 32'h0);
        run_scoreboard("word_rw");
    endtask

    task automatic test_byte_lanes();
        target = 0;
        add_wr(3'd2, 32'h20, 32'h0000_0000);
        add_wr(3'd0, 32'h22, 32'h00AB_0000);
        add_rd(3'd2, 32'h20);
        add_wr(3'd2, 32'h24, 32'h1122_3344);
        add_wr(3'd1, 32'h26, 32'hBEEF_0000);
        add_wr(3'd0, 32'h24, 32'h0000_00AA);
        add_wr(3'd1, 32'h20, 32'h0000_5566);
        add_wr(3'd0, 32'h23, 32'h7700_0000);
        add_rd(3'd2, 32'h24);
        add_rd(3'd2, 32'h20);
        run_scoreboard("byte_lanes");
    endtask

    task automatic test_no_transfer();
        target = 0;
        add_xfer(1'b0, 2'b10, 1'b1, 3'd2, 32'h10, 32'h1111_1111);
        add_xfer(1'b1, 2'b00, 1'b1, 3'd2, 32'h10, 32'h2222_2222);
        add_xfer(1'b1, 2'b01, 1'b1, 3'd2, 32'h10, 32'h3333_3333);
        add_rd(3'd2, 32'h10);
        run_scoreboard("no_transfer");
    endtask

    task automatic test_errors();
        target = 0;
        add_wr(3'd2, 32'h0, 32'h0BAD_F00D);
        add_rd(3'd2, 32'h0);
        add_rd(3'd2, 32'h2);
        add_wr(3'd2, 32'h1000, 32'hFFFF_FFFF);
        add_wr(3'd1, 32'h21, 32'hFFFF_FFFF);
        add_rd(3'd3, 32'h0);
        add_wr(3'd2, 32'hFFFF_FFF0, 32'hEEEE_EEEE);
        add_rd(3'd2, 32'h0);
        add_rd(3'd2, 32'h20);
        run_scoreboard("errors");
    endtask

    task automatic test_wait_states();
        target = 1;
        add_wr(3'd2, 32'h4, 32'h1357_9BDF);
        add_rd(3'd2, 32'h4);
        add_wr(3'd0, 32'h5, 32'h0000_4200);
        add_rd(3'd2, 32'h4);
        add_rd(3'd2, 32'h6);
        add_rd(3'd2, 32'h4);
        run_scoreboard("wait_states");
    endtask

    task automatic test_reset_mid();
        target = 2;
        add_wr(3'd2, 32'h8, 32'h1234_5678);
        run_scoreboard("reset_mid_pre");
        hsel_bus = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h8; hwdata = 32'h0;
        n_checks++;
        if (bus_ready !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL reset_mid_accept: hreadyout got %b want 1", bus_ready);
        end
        @(posedge hclk); #1;
        hsel_bus = 1'b0; htrans = 2'b00; hwdata = 32'h55AA_55AA;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (bus_ready !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL reset_mid_wait%0d: hreadyout got %b want 0", c + 1, bus_ready);
            end
            if (c == 1) hresetn = 1'b0;
            @(posedge hclk); #1;
        end
        hresetn = 1'b1;
        hwdata = 32'h0;
        for (int t = 0; t < 3; t++) last_rdata[t] = 32'h0;
        exp_q.delete();
        n_checks++;
        if ((bus_ready !== 1'b1) || (hresp_sel !== 1'b0) || (hrdata_sel !== 32'h0)) begin
            n_errors++;
            $display("[TB] FAIL reset_mid_after: got ready=%b resp=%b rdata=%h want 1 0 00000000",
                     bus_ready, hresp_sel, hrdata_sel);
        end
        add_rd(3'd2, 32'h8);
        run_scoreboard("reset_mid_read");
    endtask

    task automatic test_back_to_back();
        target = 0;
        for (int i = 0; i < 6; i++) begin
            add_wr(3'd2, 32'h100 + 32'(4 * i), $urandom);
        end
        for (int i = 0; i < 6; i++) begin
            add_rd(3'd2, 32'h100 + 32'(4 * i));
            add_wr(3'd0, 32'h100 + 32'(4 * i) + 32'(i % 4), $urandom);
            add_rd(3'd2, 32'h100 + 32'(4 * i));
        end
        run_scoreboard("back_to_back");
    endtask

    initial begin
        target = 0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_no_transfer();
        test_errors();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
